fetch_responder: RTL and testbench
==================================

Name: fetch_responder

Overview:
- Fetch-side responder between the PC generator and a multi-cycle instruction memory.
- Takes the current fetch address PCF_i and runs a req/ack transaction with instruction memory.
- Presents the returned instruction to the IF/ID register with a valid flag.
- Drives PCen_o so the PC advances only when a fetch completes, or when a branch/jump redirect is signalled. Discards in-flight responses made stale by a redirect.

Parameters:
- DATA_WIDTH, 32, width of addresses and instruction words.
- MAX_WAIT, 15, cycles without mem_ack_i before fetch_err_o sets (counter width = $clog2(MAX_WAIT+1)).
- NOP_INSTR, 32'h00000013, value driven on InstrF_o when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- PCF_i  input  DATA_WIDTH  current fetch address from the PC register.
- PCSrc_i  input  2  PC select; any non-zero value means redirect (target or ALU result).
- StallD_i  input  1  decode stage cannot accept a new instruction.
- mem_req_o  output  1  instruction memory request.
- mem_addr_o  output  DATA_WIDTH  request address; stable while mem_req_o=1.
- mem_ack_i  input  1  memory has returned data this cycle.
- mem_rdata_i  input  DATA_WIDTH  instruction word, valid when mem_ack_i=1.
- InstrF_o  output  DATA_WIDTH  fetched instruction to IF/ID.
- InstrValidF_o  output  1  InstrF_o holds a live instruction.
- PCen_o  output  1  PC register enable.
- fetch_err_o  output  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, addr_q=0, instr_q=NOP_INSTR, wait counter=0, fetch_err_o=0.
  - All other outputs are low.
- IDLE:
  - mem_req_o=0.
  - If PCSrc_i!=0: PCen_o=1, stay IDLE, do not capture PCF_i.
  - Else: addr_q<=PCF_i, go BUSY.
- BUSY:
  - mem_req_o=1, mem_addr_o=addr_q.
  - ack and PCSrc_i==0: instr_q<=mem_rdata_i, go VALID.
  - ack and PCSrc_i!=0: discard data, PCen_o=1, go IDLE.
  - No ack and PCSrc_i!=0: PCen_o=1, go DRAIN. A request is never withdrawn before ack.
  - No ack and no redirect: stay BUSY.
- DRAIN:
  - mem_req_o=1, addr unchanged.
  - On ack: discard data, go IDLE.
  - A further redirect here: PCen_o=1, stay DRAIN.
- VALID:
  - InstrValidF_o=1, InstrF_o=instr_q.
  - PCSrc_i!=0 (highest priority): InstrValidF_o=0 (squash), PCen_o=1, go IDLE.
  - Else StallD_i=1: hold, PCen_o=0.
  - Else: PCen_o=1, instr_q<=NOP_INSTR, go IDLE.
- Whenever InstrValidF_o=0, InstrF_o=NOP_INSTR.
- PCen_o is purely combinational from state, PCSrc_i, StallD_i and mem_ack_i. Redirect always wins over stall.
- Latency, zero-wait memory: IDLE, BUSY (ack), VALID = 3 cycles per instruction; each wait state adds 1.
- Timeout:
  - Wait counter counts cycles in BUSY/DRAIN without ack; clears on ack or on leaving those states.
  - When it reaches MAX_WAIT, fetch_err_o<=1 and stays set until reset.
  - FSM keeps waiting; the counter saturates.
- Address width: mem_addr_o is the full DATA_WIDTH. Bits [1:0] are passed unmodified; alignment is not this block's concern.
- Reset mid-transaction: the FSM returns to IDLE immediately and mem_req_o drops asynchronously. The memory must tolerate an aborted request under reset.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, BUSY, VALID, DRAIN}.
  - NOP_INSTR constant.
  - PCSrc encodings PCSRC_PLUS4=2'd0, PCSRC_TARGET=2'd1, PCSRC_ALU=2'd2.
- One sub-module, fetch_wait_timer: saturating counter with clear/enable and MAX_WAIT parameter, producing the timeout pulse.

Test Plan:
- Reset release, PCF_i=0x0, ack on first BUSY cycle with rdata=0x00500093:
  - mem_req_o rises in cycle 2 with addr 0x0.
  - InstrValidF_o=1 and InstrF_o=0x00500093 in cycle 3.
  - PCen_o=1 in cycle 3.
- Memory with 4 wait states, PCF_i=0x10:
  - mem_req_o stays high with addr 0x10 for 5 cycles.
  - PCen_o=0 throughout; VALID on the cycle after ack.
- VALID with StallD_i=1 for 3 cycles:
  - InstrF_o held and PCen_o=0 for those 3 cycles.
  - PCen_o=1 on the first cycle StallD_i=0.
- Redirect (PCSrc_i=1) during BUSY with ack 2 cycles later:
  - PCen_o=1 in the redirect cycle; FSM enters DRAIN.
  - Acked data 0xDEADBEEF never appears on InstrF_o; next request uses the new PCF_i.
- Redirect and StallD_i=1 together in VALID:
  - InstrValidF_o=0, InstrF_o=0x00000013, PCen_o=1; FSM enters IDLE.
- No ack for 16 cycles:
  - fetch_err_o=1 after the 15th waiting cycle and stays 1 after a later ack.
  - Cleared only by rst_n=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch responder: FSM state encoding,
// the canonical NOP, and the PC-select encodings seen on PCSrc.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] PCSRC_PLUS4  = 2'd0;
  localparam logic [1:0] PCSRC_TARGET = 2'd1;
  localparam logic [1:0] PCSRC_ALU    = 2'd2;

  // Any select other than PC+4 is a control-flow redirect.
  function automatic logic is_redirect(input logic [1:0] pcsrc);
    return pcsrc != PCSRC_PLUS4;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating wait counter for outstanding memory requests; emits a single-cycle
// timeout pulse on the cycle whose increment brings the count to MAX_WAIT.
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_L = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          at_max;

  assign cnt_inc = cnt_q + CW'(1);
  assign at_max  = (cnt_q == MAX_L);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_max) begin
      cnt_d = cnt_inc;
    end
  end

  // Pulse coincides with the count becoming MAX_WAIT, so the sticky flag
  // downstream is visible right after the MAX_WAIT-th waiting cycle.
  assign timeout_o = !clr_i && en_i && !at_max && (cnt_inc == MAX_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_responder.sv
// Fetch-side responder: runs one req/ack instruction-memory transaction per PC,
// presents the result to IF/ID, gates the PC enable and drops stale responses.
module fetch_responder
  import fetch_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            MAX_WAIT   = 15,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  input  logic [1:0]            PCSrc_i,
  input  logic                  StallD_i,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] InstrF_o,
  output logic                  InstrValidF_o,
  output logic                  PCen_o,
  output logic                  fetch_err_o
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  err_q, err_d;
  logic                  redirect;
  logic                  tmr_en, tmr_clr, timeout;

  assign redirect = is_redirect(PCSrc_i);

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    instr_d       = instr_q;
    mem_req_o     = 1'b0;
    InstrValidF_o = 1'b0;
    PCen_o        = 1'b0;
    tmr_en        = 1'b0;
    tmr_clr       = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          PCen_o = 1'b1;
        end else begin
          addr_d  = PCF_i;
          state_d = BUSY;
        end
      end

      BUSY: begin
        mem_req_o = 1'b1;
        tmr_clr   = mem_ack_i;
        tmr_en    = !mem_ack_i;
        if (mem_ack_i) begin
          if (redirect) begin
            PCen_o  = 1'b1;
            state_d = IDLE;
          end else begin
            instr_d = mem_rdata_i;
            state_d = VALID;
          end
        end else if (redirect) begin
          // Request stays up until acked; its data is thrown away in DRAIN.
          PCen_o  = 1'b1;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        mem_req_o = 1'b1;
        tmr_clr   = mem_ack_i;
        tmr_en    = !mem_ack_i;
        if (redirect) begin
          PCen_o = 1'b1;
        end
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end

      VALID: begin
        if (redirect) begin
          PCen_o  = 1'b1;
          state_d = IDLE;
        end else if (StallD_i) begin
          InstrValidF_o = 1'b1;
        end else begin
          InstrValidF_o = 1'b1;
          PCen_o        = 1'b1;
          instr_d       = NOP_INSTR;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign err_d       = err_q | timeout;
  assign mem_addr_o  = addr_q;
  assign InstrF_o    = InstrValidF_o ? instr_q : NOP_INSTR;
  assign fetch_err_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Scripted cycle-by-cycle bench for fetch_responder with an instruction
// scoreboard: deliverable acked words are queued and matched on InstrF_o.
module tb_fetch_responder;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF_i;
  logic [1:0]  PCSrc_i;
  logic        StallD_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] InstrF_o;
  logic        InstrValidF_o;
  logic        PCen_o;
  logic        fetch_err_o;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] expq[$];

  fetch_responder #(
    .DATA_WIDTH (32),
    .MAX_WAIT   (15),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCF_i         (PCF_i),
    .PCSrc_i       (PCSrc_i),
    .StallD_i      (StallD_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .InstrF_o      (InstrF_o),
    .InstrValidF_o (InstrValidF_o),
    .PCen_o        (PCen_o),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] pcsrc, input logic stall,
                       input logic ack, input logic [31:0] rdata);
    PCSrc_i     = pcsrc;
    StallD_i    = stall;
    mem_ack_i   = ack;
    mem_rdata_i = rdata;
  endtask

  // Ack whose data must reach IF/ID.
  task automatic ack_push(input logic [31:0] rdata);
    drive(PCSRC_PLUS4, 1'b0, 1'b1, rdata);
    expq.push_back(rdata);
  endtask

  // Mid-cycle sample with scoreboard match on any live instruction.
  task automatic sample();
    @(negedge clk);
    if (InstrValidF_o) begin
      if (expq.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("sb_instr", InstrF_o, expq[0]);
        if (PCSrc_i != PCSRC_PLUS4 || !StallD_i) void'(expq.pop_front());
      end
    end else begin
      chk("nop_when_invalid", InstrF_o, NOP);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    PCF_i = 32'h0;
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);

    // Reset state
    #2;
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_valid", InstrValidF_o, 0);
    chk("rst_instr", InstrF_o, NOP);
    chk("rst_pcen", PCen_o, 0);
    chk("rst_err", fetch_err_o, 0);
    tick();
    rst_n = 1'b1;

    // Zero-wait fetch at 0x0
    sample();
    chk("t1_c1_req", mem_req_o, 0);
    chk("t1_c1_pcen", PCen_o, 0);
    tick();
    ack_push(32'h0050_0093);
    sample();
    chk("t1_c2_req", mem_req_o, 1);
    chk("t1_c2_addr", mem_addr_o, 32'h0);
    chk("t1_c2_pcen", PCen_o, 0);
    tick();
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t1_c3_valid", InstrValidF_o, 1);
    chk("t1_c3_instr", InstrF_o, 32'h0050_0093);
    chk("t1_c3_pcen", PCen_o, 1);
    tick();

    // Four wait states at 0x10, then stall in VALID for three cycles
    PCF_i = 32'h10;
    sample();
    chk("t2_idle_req", mem_req_o, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ack_push(32'h00A0_0113);
      else drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'hBAD0_0000);
      sample();
      chk("t2_busy_req", mem_req_o, 1);
      chk("t2_busy_addr", mem_addr_o, 32'h10);
      chk("t2_busy_pcen", PCen_o, 0);
      chk("t2_busy_valid", InstrValidF_o, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(PCSRC_PLUS4, 1'b1, 1'b0, 32'h0);
      sample();
      chk("t3_stall_valid", InstrValidF_o, 1);
      chk("t3_stall_instr", InstrF_o, 32'h00A0_0113);
      chk("t3_stall_pcen", PCen_o, 0);
      tick();
    end
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t3_release_valid", InstrValidF_o, 1);
    chk("t3_release_pcen", PCen_o, 1);
    tick();

    // Redirect during BUSY, stale ack drained, new PC fetched
    PCF_i = 32'h20;
    sample();
    chk("t4_idle_req", mem_req_o, 0);
    tick();
    drive(PCSRC_TARGET, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t4_redir_req", mem_req_o, 1);
    chk("t4_redir_addr", mem_addr_o, 32'h20);
    chk("t4_redir_pcen", PCen_o, 1);
    tick();
    PCF_i = 32'h40;
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t4_drain_req", mem_req_o, 1);
    chk("t4_drain_addr", mem_addr_o, 32'h20);
    chk("t4_drain_pcen", PCen_o, 0);
    tick();
    drive(PCSRC_ALU, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t4_drain_redir_req", mem_req_o, 1);
    chk("t4_drain_redir_pcen", PCen_o, 1);
    tick();
    drive(PCSRC_PLUS4, 1'b0, 1'b1, 32'hDEAD_BEEF);
    sample();
    chk("t4_drain_ack_req", mem_req_o, 1);
    chk("t4_drain_ack_valid", InstrValidF_o, 0);
    tick();
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t4_post_drain_req", mem_req_o, 0);
    chk("t4_post_drain_valid", InstrValidF_o, 0);
    chk("t4_no_stale", InstrF_o, NOP);
    tick();
    drive(PCSRC_PLUS4, 1'b0, 1'b1, 32'h1111_1111);
    sample();
    chk("t4_new_req", mem_req_o, 1);
    chk("t4_new_addr", mem_addr_o, 32'h40);
    tick();

    // Redirect and stall together in VALID: squash wins
    drive(PCSRC_TARGET, 1'b1, 1'b0, 32'h0);
    sample();
    chk("t5_squash_valid", InstrValidF_o, 0);
    chk("t5_squash_instr", InstrF_o, NOP);
    chk("t5_squash_pcen", PCen_o, 1);
    tick();
    PCF_i = 32'h80;
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t5_idle_req", mem_req_o, 0);
    chk("t5_idle_valid", InstrValidF_o, 0);
    tick();

    // Timeout: 16 cycles without ack
    for (int i = 1; i <= 16; i++) begin
      drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
      sample();
      chk("t6_wait_req", mem_req_o, 1);
      chk("t6_wait_addr", mem_addr_o, 32'h80);
      chk("t6_wait_err", fetch_err_o, (i == 16) ? 32'd1 : 32'd0);
      tick();
    end
    ack_push(32'hCAFE_0013);
    sample();
    chk("t6_ack_err", fetch_err_o, 1);
    tick();
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t6_valid", InstrValidF_o, 1);
    chk("t6_valid_err", fetch_err_o, 1);
    tick();
    sample();
    chk("t6_idle_err", fetch_err_o, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_err_cleared", fetch_err_o, 0);
    tick();
    rst_n = 1'b1;

    // Redirect in IDLE, then reset during a live request
    PCF_i = 32'hC4;
    drive(PCSRC_ALU, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t7_idle_redir_pcen", PCen_o, 1);
    chk("t7_idle_redir_req", mem_req_o, 0);
    tick();
    drive(PCSRC_PLUS4, 1'b0, 1'b0, 32'h0);
    sample();
    chk("t7_still_idle_req", mem_req_o, 0);
    chk("t7_still_idle_pcen", PCen_o, 0);
    tick();
    sample();
    chk("t7_busy_req", mem_req_o, 1);
    chk("t7_busy_addr", mem_addr_o, 32'hC4);
    rst_n = 1'b0;
    #1;
    chk("t7_async_req_drop", mem_req_o, 0);
    chk("t7_async_addr", mem_addr_o, 32'h0);
    tick();
    rst_n = 1'b1;
    sample();
    chk("t7_after_rst_req", mem_req_o, 0);

    chk("sb_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
